// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: instruction-memory port, redirect input and decode handshake.
interface fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
    logic        fault_hold;

    // Fetch controller side
    modport master (
        output imem_addr,
        input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        input  redirect_en, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc, out_exc_en, out_exc_code, out_exc_val,
        output fault_hold
    );

    // Memory / pipeline side
    modport slave (
        input  imem_addr,
        output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        output redirect_en, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc, out_exc_en, out_exc_code, out_exc_val,
        input  fault_hold
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, buffers fetched words in a small
// circular queue for decode, handles redirects and parks after a fault.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master io_fc
);

    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_pc;
    logic [63:0]      w_pc_nxt;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_mem [FQ_DEPTH];
    entry_t           w_entry;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;
    logic             w_not_empty;
    logic             w_full;

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_W'(FQ_DEPTH));

    // Head is hidden during a redirect so a pop can never race the flush
    assign io_fc.out_valid = w_not_empty & ~io_fc.redirect_en;
    assign w_pop           = io_fc.out_valid & io_fc.out_ready;

    // Head fields read as zero while the queue is empty
    assign w_head             = w_not_empty ? r_mem[r_rptr] : '0;
    assign io_fc.out_instr    = w_head.instr;
    assign io_fc.out_pc       = w_head.pc;
    assign io_fc.out_exc_en   = w_head.exc_en;
    assign io_fc.out_exc_code = w_head.code;
    assign io_fc.out_exc_val  = w_head.val;

    assign io_fc.imem_addr  = r_pc;
    assign io_fc.fault_hold = (r_state == ST_HOLD);

    // State and PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC and the entry to enqueue this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_entry     = '0;
        if (io_fc.redirect_en) begin
            w_pc_nxt    = io_fc.redirect_pc;
            w_state_nxt = ST_FETCH;
        end else if ((r_state == ST_FETCH) && (!w_full || w_pop)) begin
            w_push   = 1'b1;
            w_entry.pc = r_pc;
            if (r_pc[1:0] != 2'b00) begin
                // Misaligned PC: memory response is irrelevant
                w_entry.instr  = NOP_INSTR;
                w_entry.exc_en = 1'b1;
                w_entry.code   = 4'd0;
                w_entry.val    = r_pc;
                w_state_nxt    = ST_HOLD;
            end else if (io_fc.imem_exc_en) begin
                w_entry.instr  = NOP_INSTR;
                w_entry.exc_en = 1'b1;
                w_entry.code   = io_fc.imem_exc_code;
                w_entry.val    = io_fc.imem_exc_val;
                w_state_nxt    = ST_HOLD;
            end else begin
                w_entry.instr = io_fc.imem_instr;
                w_pc_nxt      = r_pc + 64'd4;
            end
        end
    end

    // Queue pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk) begin
        if (rst || io_fc.redirect_en) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Queue storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned FQ_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exc_en;
        logic [3:0]  code;
        logic [63:0] val;
    } ent_t;

    logic clk;
    logic rst;
    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_fc (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word content from address, faults from config or random injection
    logic [31:0] salt;
    logic        f_en;
    logic [63:0] f_addr;
    logic [3:0]  f_code;
    logic        r_exc;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return (32'h100 + 32'(a >> 2)) ^ salt;
    endfunction

    assign bus.imem_instr    = imem_word(bus.imem_addr);
    assign bus.imem_exc_en   = (f_en && (bus.imem_addr == f_addr)) || r_exc;
    assign bus.imem_exc_code = f_code;
    assign bus.imem_exc_val  = bus.imem_addr;

    // Reference model state
    logic [63:0] m_pc;
    bit          m_hold;
    ent_t        m_q[$];

    int n_checks;
    int n_errors;

    // Advance the model by one clock using current inputs, then step the DUT
    task automatic cycle();
        bit   pop;
        bit   can_push;
        bit   exc;
        ent_t e;
        pop = (m_q.size() != 0) && !bus.redirect_en && bus.out_ready;
        if (rst) begin
            m_pc   = RESET_PC;
            m_hold = 0;
            m_q.delete();
        end else if (bus.redirect_en) begin
            m_pc   = bus.redirect_pc;
            m_hold = 0;
            m_q.delete();
        end else begin
            can_push = !m_hold && ((m_q.size() < FQ_DEPTH) || pop);
            if (pop) void'(m_q.pop_front());
            if (can_push) begin
                exc = (f_en && (m_pc == f_addr)) || r_exc;
                e.pc = m_pc;
                if (m_pc % 4 != 0) begin
                    e.instr = 32'h13; e.exc_en = 1; e.code = 4'd0; e.val = m_pc;
                    m_hold = 1;
                end else if (exc) begin
                    e.instr = 32'h13; e.exc_en = 1; e.code = f_code; e.val = m_pc;
                    m_hold = 1;
                end else begin
                    e.instr = imem_word(m_pc); e.exc_en = 0; e.code = 0; e.val = 0;
                    m_pc = m_pc + 64'd4;
                end
                m_q.push_back(e);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_valid: got %b exp 0", bus.out_valid);
        end
        n_checks++;
        if (bus.imem_addr !== RESET_PC) begin
            n_errors++; $display("FAIL reset_addr: got %h exp %h", bus.imem_addr, RESET_PC);
        end
        n_checks++;
        if (bus.fault_hold !== 1'b0) begin
            n_errors++; $display("FAIL reset_hold: got %b exp 0", bus.fault_hold);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc_en} !==
                {1'b1, 64'(4 * i), 32'h100 + 32'(i), 1'b0}) begin
                n_errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h exc=%b exp pc=%h instr=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instr, bus.out_exc_en,
                         64'(4 * i), 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_pc;
        int got;
        bus.out_ready   = 1'b0;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'h0;
        cycle();
        bus.redirect_en = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h0}) begin
            n_errors++; $display("FAIL bp_head: got v=%b pc=%h exp v=1 pc=0", bus.out_valid, bus.out_pc);
        end
        n_checks++;
        if (bus.imem_addr !== 64'h8) begin
            n_errors++; $display("FAIL bp_addr: got %h exp 8", bus.imem_addr);
        end
        bus.out_ready = 1'b1;
        exp_pc = 64'h0;
        got = 0;
        for (int i = 0; i < 6 && got < 3; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (bus.out_pc !== exp_pc) begin
                    n_errors++; $display("FAIL bp_order: got %h exp %h", bus.out_pc, exp_pc);
                end
                exp_pc = exp_pc + 64'd4;
                got++;
            end
            cycle();
        end
        n_checks++;
        if (got != 3) begin
            n_errors++; $display("FAIL bp_count: got %0d exp 3", got);
        end
    endtask

    task automatic test_fault();
        bus.out_ready   = 1'b1;
        f_en = 1'b1; f_addr = 64'h20000; f_code = 4'd1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'h20000;
        cycle();
        bus.redirect_en = 1'b0;
        cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val, bus.out_instr} !==
            {1'b1, 64'h20000, 1'b1, 4'd1, 64'h20000, 32'h13}) begin
            n_errors++;
            $display("FAIL fault_entry: got v=%b pc=%h exc=%b code=%h val=%h instr=%h",
                     bus.out_valid, bus.out_pc, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val, bus.out_instr);
        end
        n_checks++;
        if (bus.fault_hold !== 1'b1) begin
            n_errors++; $display("FAIL fault_hold: got %b exp 1", bus.fault_hold);
        end
        cycle();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({bus.out_valid, bus.fault_hold} !== 2'b01) begin
                n_errors++; $display("FAIL fault_quiet_%0d: got v=%b hold=%b exp v=0 hold=1", i, bus.out_valid, bus.fault_hold);
            end
            cycle();
        end
        f_en = 1'b0;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'h40;
        cycle();
        bus.redirect_en = 1'b0;
        #1;
        n_checks++;
        if (bus.fault_hold !== 1'b0) begin
            n_errors++; $display("FAIL fault_release: got %b exp 0", bus.fault_hold);
        end
        cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_exc_en} !== {1'b1, 64'h40, 1'b0}) begin
            n_errors++; $display("FAIL fault_resume: got v=%b pc=%h exc=%b exp pc=40", bus.out_valid, bus.out_pc, bus.out_exc_en);
        end
    endtask

    task automatic test_redirect_full();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        bus.out_ready   = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'h80;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL redir_valid: got %b exp 0", bus.out_valid);
        end
        cycle();
        bus.redirect_en = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL redir_flushed: got %b exp 0", bus.out_valid);
        end
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h80 + 64'(4 * i)}) begin
                n_errors++; $display("FAIL redir_seq_%0d: got v=%b pc=%h exp %h", i, bus.out_valid, bus.out_pc, 64'h80 + 64'(4 * i));
            end
            cycle();
        end
    endtask

    task automatic test_misaligned();
        bus.out_ready = 1'b1;
        f_en = 1'b1; f_addr = 64'h102; f_code = 4'd5;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'h102;
        cycle();
        bus.redirect_en = 1'b0;
        cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val} !==
            {1'b1, 64'h102, 1'b1, 4'd0, 64'h102}) begin
            n_errors++;
            $display("FAIL misaligned_entry: got v=%b pc=%h exc=%b code=%h val=%h exp code=0 val=102",
                     bus.out_valid, bus.out_pc, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val);
        end
        n_checks++;
        if (bus.fault_hold !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_hold: got %b exp 1", bus.fault_hold);
        end
        cycle();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL misaligned_single: got %b exp 0", bus.out_valid);
        end
        f_en = 1'b0;
    endtask

    task automatic test_wrap_reset();
        bus.out_ready   = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        bus.redirect_en = 1'b0;
        cycle();
        #1;
        n_checks++;
        if (bus.out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_top: got %h exp fffffffffffffffc", bus.out_pc);
        end
        cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 64'h0}) begin
            n_errors++; $display("FAIL wrap_zero: got v=%b pc=%h exp pc=0", bus.out_valid, bus.out_pc);
        end
        bus.out_ready = 1'b0;
        cycle();
        #1;
        n_checks++;
        if (bus.imem_addr !== 64'h8) begin
            n_errors++; $display("FAIL wrap_full_addr: got %h exp 8", bus.imem_addr);
        end
        rst = 1'b1;
        cycle();
        #1;
        n_checks++;
        if ({bus.out_valid, bus.imem_addr} !== {1'b0, RESET_PC}) begin
            n_errors++; $display("FAIL midreset: got v=%b addr=%h exp v=0 addr=%h", bus.out_valid, bus.imem_addr, RESET_PC);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] rp;
        bit          exp_valid;
        salt = $urandom;
        for (int i = 0; i < 400; i++) begin
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect_en = ($urandom_range(0, 19) == 0);
            rp = {$urandom, $urandom};
            rp[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.redirect_pc = rp;
            r_exc  = ($urandom_range(0, 29) == 0);
            f_code = 4'($urandom);
            #1;
            exp_valid = (m_q.size() != 0) && !bus.redirect_en;
            n_checks++;
            if (bus.out_valid !== exp_valid) begin
                n_errors++; $display("FAIL rand_valid_%0d: got %b exp %b", i, bus.out_valid, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if ({bus.out_instr, bus.out_pc, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val} !== m_q[0]) begin
                    n_errors++;
                    $display("FAIL rand_head_%0d: got pc=%h instr=%h exc=%b code=%h val=%h exp pc=%h instr=%h exc=%b code=%h val=%h",
                             i, bus.out_pc, bus.out_instr, bus.out_exc_en, bus.out_exc_code, bus.out_exc_val,
                             m_q[0].pc, m_q[0].instr, m_q[0].exc_en, m_q[0].code, m_q[0].val);
                end
            end
            n_checks++;
            if ({bus.imem_addr, bus.fault_hold} !== {m_pc, m_hold}) begin
                n_errors++;
                $display("FAIL rand_pc_%0d: got addr=%h hold=%b exp addr=%h hold=%b",
                         i, bus.imem_addr, bus.fault_hold, m_pc, m_hold);
            end
            cycle();
        end
        r_exc = 1'b0;
        bus.redirect_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        salt = 32'h0;
        f_en = 1'b0; f_addr = 64'h0; f_code = 4'd0; r_exc = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.out_ready   = 1'b0;
        m_pc = RESET_PC;
        m_hold = 0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_fault();
        test_redirect_full();
        test_misaligned();
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
